// File: rtl/serial_sub_16bit.sv
// ----------------------------------------------------------------------------
// serial_sub_16bit
//   Bit-serial two's-complement subtractor computing Diff = A - B, LSB first,
//   one bit per clock. A single full-adder slice adds A to ~B. The carry is
//   seeded to 1, which completes the two's-complement negation of B.
//
//   Timing: start accepted at edge 0, busy high for cycles 1..WIDTH, done
//   pulses in cycle WIDTH+1. The FSM then returns to idle, so one operation
//   completes every WIDTH+2 cycles.
//
// Configuration macro:
//   SERIAL_SUB_SAT_EN  when defined, a signed overflow clamps Diff to the most
//                      positive or most negative value, chosen by the sign of A.
//                      Ovfl still reports the overflow, and Zero is computed on
//                      the clamped value.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   start   in   1      request, sampled only in idle
//   A       in   WIDTH  minuend, captured on accepted start
//   B       in   WIDTH  subtrahend, captured on accepted start
//   busy    out  1      high while bits are being shifted
//   done    out  1      one-cycle pulse when the result is valid
//   Diff    out  WIDTH  result, held until the next completed operation
//   Ovfl    out  1      signed overflow of A - B
//   Borrow  out  1      unsigned borrow (A < B), equal to ~final carry
//   Zero    out  1      Diff == 0
// ----------------------------------------------------------------------------
module serial_sub_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Ovfl,
    output logic             Borrow,
    output logic             Zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // Only WIDTH-1 sum bits need storing. The last sum bit is merged
    // combinationally when the result is committed.
    logic [WIDTH-2:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic             bit_a;
    logic             bit_b;
    logic             sum;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;
    logic             ovfl_d;
    logic [WIDTH-1:0] final_d;

    // One-bit datapath slice.
    always_comb begin
        bit_a   = a_q[0];
        bit_b   = ~b_q[0];
        sum     = bit_a ^ bit_b ^ carry_q;
        carry_d = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        res_d   = {sum, res_q};
        // Overflow is only possible when the operand signs differ.
        // It has occurred when the result sign differs from the sign of A.
        ovfl_d  = (a_msb_q != b_msb_q) & (res_d[WIDTH-1] != a_msb_q);
`ifdef SERIAL_SUB_SAT_EN
        if (ovfl_d) begin
            final_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_d = res_d;
        end
`else
        final_d = res_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Ovfl    <= 1'b0;
            Borrow  <= 1'b0;
            Zero    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        a_msb_q <= A[WIDTH-1];
                        b_msb_q <= B[WIDTH-1];
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LastCnt) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Diff    <= final_d;
                        Ovfl    <= ovfl_d;
                        Borrow  <= ~carry_d;
                        Zero    <= (final_d == '0);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_16bit.sv
// ----------------------------------------------------------------------------
// tb_serial_sub_16bit
//   Directed self-checking bench for serial_sub_16bit (WIDTH=16). The expected
//   Diff and flag values are hand-computed. Saturated expectations apply when
//   SERIAL_SUB_SAT_EN is defined.
// ----------------------------------------------------------------------------
module tb_serial_sub_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Ovfl;
    logic        Borrow;
    logic        Zero;

    int total;
    int bad;

    serial_sub_16bit #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Ovfl  (Ovfl),
        .Borrow(Borrow),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one subtraction from an idle cycle (sampled 1 time unit after an edge).
    // Checks latency, the busy length, the held previous result, the final result
    // and flags, and the one-cycle done pulse. If poke is nonzero, start is raised
    // again in that SHIFT cycle with different operands, and it must be ignored.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic eo, input logic eb,
                          input logic ez, input int poke);
        logic [15:0] prev;
        int          busy_n;
        int          cyc;
        bit          seen;
        prev  = Diff;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cyc    = 1;
        busy_n = 0;
        seen   = 0;
        while (cyc <= 40 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_n++;
                if (cyc == 3) check_val({tag, "_hold"}, 32'(Diff), 32'(prev));
                if (poke != 0 && cyc == poke) begin
                    A     = ~a;
                    B     = 16'h0000;
                    start = 1'b1;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_latency"}, 32'(cyc), 32'd17);
        check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
        check_val({tag, "_diff"}, 32'(Diff), 32'(ed));
        check_val({tag, "_ovfl"}, 32'(Ovfl), 32'(eo));
        check_val({tag, "_borrow"}, 32'(Borrow), 32'(eb));
        check_val({tag, "_zero"}, 32'(Zero), 32'(ez));
        check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_diff_kept"}, 32'(Diff), 32'(ed));
    endtask

    initial begin
        int done_cnt;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_diff", 32'(Diff), 32'd0);
        check_val("rst_ovfl", 32'(Ovfl), 32'd0);
        check_val("rst_borrow", 32'(Borrow), 32'd0);
        check_val("rst_zero", 32'(Zero), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("t1_5m3", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
        run_op("t2_3m5", 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 0);
        run_op("t3_eq", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
`ifdef SERIAL_SUB_SAT_EN
        run_op("t4_negovf", 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 0);
        run_op("t5_posovf", 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
`else
        run_op("t4_negovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("t5_posovf", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 0);
`endif
        run_op("b_zero", 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0, 1'b0, 0);
        run_op("all_zero", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        run_op("wrap", 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0);
        // Start raised again mid-shift must not restart or alter the operation.
        run_op("ign_start", 16'h4321, 16'h0123, 16'h41FE, 1'b0, 1'b0, 1'b0, 5);

        // Reset in the middle of a shift aborts the operation, with no done pulse.
        A     = 16'h00FF;
        B     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (c == 5) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_val("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_diff", 32'(Diff), 32'd0);
        check_val("abort_zero", 32'(Zero), 32'd1);
        check_val("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) done_cnt++;
            @(posedge clk);
            #1;
        end
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        run_op("after_abort", 16'h00FF, 16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
